// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz timing constants, axis phase encoding and RRRGGGBB colour expansion helpers.
// Shared by the per-axis counters and the scanout top level.
package vga_timing_pkg;

    localparam int CNT_W    = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Bit replication so that full-scale codes reach 8'hFF exactly.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Flags are registered state (zero latency from the count); no backpressure, advances when i_adv is high.
import vga_timing_pkg::*;

module vga_axis_counter #(
    parameter int P_ACTIVE = 640,
    parameter int P_FRONT  = 16,
    parameter int P_SYNC   = 96,
    parameter int P_BACK   = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_active,
    output logic             o_sync
);

    localparam int TOTAL = P_ACTIVE + P_FRONT + P_SYNC + P_BACK;

    localparam logic [CNT_W-1:0] L_FRONT = CNT_W'(P_ACTIVE);
    localparam logic [CNT_W-1:0] L_SYNC  = CNT_W'(P_ACTIVE + P_FRONT);
    localparam logic [CNT_W-1:0] L_BACK  = CNT_W'(P_ACTIVE + P_FRONT + P_SYNC);
    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    phase_e           r_phase;
    phase_e           w_phase_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_adv) begin
            w_cnt_nxt = (r_cnt == L_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // Phase moves on the same edge as the count that enters the new region.
    always_comb begin
        w_phase_nxt = r_phase;
        if (i_adv) begin
            case (r_phase)
                PH_ACTIVE: if (w_cnt_nxt == L_FRONT) w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (w_cnt_nxt == L_SYNC)  w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (w_cnt_nxt == L_BACK)  w_phase_nxt = PH_BACK;
                PH_BACK:   if (w_cnt_nxt == '0)      w_phase_nxt = PH_ACTIVE;
                default:                             w_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= PH_ACTIVE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_active = (r_phase == PH_ACTIVE);
    assign o_sync   = (r_phase == PH_SYNC);

endmodule

// File: rtl/vga_scanout.sv
// 640x480@60 Hz scanout: coordinates out, colour in, registered sync/blank/RGB to the DAC.
// Latency one cycle from coordinate to DAC outputs; no backpressure, colour must be valid every cycle.
import vga_timing_pkg::*;

module vga_scanout (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       color_in,
    output logic [CNT_W-1:0] next_x,
    output logic [CNT_W-1:0] next_y,
    output logic             hsync,
    output logic             vsync,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             sync,
    output logic             clk,
    output logic             blank,
    output logic             frame_tick
);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_active;
    logic             w_h_sync;
    logic             w_v_active;
    logic             w_v_sync;
    logic             w_line_end;
    logic             w_visible;
    logic             w_frame_end;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank;
    logic             r_frame_tick;
    logic [7:0]       r_red;
    logic [7:0]       r_green;
    logic [7:0]       r_blue;

    assign w_line_end = (w_h_cnt == CNT_W'(H_TOTAL - 1));

    vga_axis_counter #(
        .P_ACTIVE (H_ACTIVE),
        .P_FRONT  (H_FRONT),
        .P_SYNC   (H_SYNC),
        .P_BACK   (H_BACK)
    ) u_h_axis (
        .clock    (clock),
        .reset    (reset),
        .i_adv    (1'b1),
        .o_cnt    (w_h_cnt),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    vga_axis_counter #(
        .P_ACTIVE (V_ACTIVE),
        .P_FRONT  (V_FRONT),
        .P_SYNC   (V_SYNC),
        .P_BACK   (V_BACK)
    ) u_v_axis (
        .clock    (clock),
        .reset    (reset),
        .i_adv    (w_line_end),
        .o_cnt    (w_v_cnt),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    assign w_visible   = w_h_active & w_v_active;
    assign w_frame_end = (w_h_cnt == '0) && (w_v_cnt == CNT_W'(V_ACTIVE));

    assign next_x = w_h_active ? w_h_cnt : '0;
    assign next_y = w_v_active ? w_v_cnt : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_blank      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
        end else begin
            r_hsync      <= ~w_h_sync;
            r_vsync      <= ~w_v_sync;
            r_blank      <= w_visible;
            r_frame_tick <= w_frame_end;
            r_red        <= w_visible ? expand3(color_in[7:5]) : '0;
            r_green      <= w_visible ? expand3(color_in[4:2]) : '0;
            r_blue       <= w_visible ? expand2(color_in[1:0]) : '0;
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign blank      = r_blank;
    assign frame_tick = r_frame_tick;
    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;
    assign sync       = 1'b0;
    assign clk        = clock;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset, with ports named clock and reset.
REQ-002 Port clock  input  1  25 MHz pixel clock; all state SHALL change on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port color_in  input  8  pixel colour in RRRGGGBB format, for the pixel at (next_x, next_y).
REQ-005 Port next_x  output  10  column whose colour is sampled this cycle.
REQ-006 Port next_y  output  10  row whose colour is sampled this cycle.
REQ-007 Port hsync  output  1  horizontal sync, active-low.
REQ-008 Port vsync  output  1  vertical sync, active-low.
REQ-009 Port red / green / blue  output  8 each  expanded colour to the DAC.
REQ-010 Port sync  output  1  composite sync to the DAC, held constant 0.
REQ-011 Port clk  output  1  DAC clock, equal to clock (pass-through).
REQ-012 Port blank  output  1  DAC blank, active-low: 0 means blanked.
REQ-013 Port frame_tick  output  1  one-cycle pulse at the end of each visible frame.

Function
REQ-014 Timing SHALL be 640x480 at 60 Hz.
  - Horizontal: 640 active, 16 front porch, 96 sync, 48 back porch; total 800.
  - Vertical: 480 active, 10 front porch, 2 sync, 33 back porch; total 525.
REQ-015 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment only when h_cnt wraps 799->0, and SHALL wrap 524->0 on the same edge as h_cnt 799->0.
REQ-016 Each axis SHALL track a phase FSM ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Horizontal transitions at h_cnt 640, 656, 752, 0.
  - Vertical transitions at v_cnt 480, 490, 492, 0.
REQ-017 next_x SHALL equal h_cnt while h_cnt<640, else 0; next_y SHALL equal v_cnt while v_cnt<480, else 0 (combinational from the counters).
REQ-018 color_in SHALL be registered on the edge after next_x/next_y present a coordinate; red/green/blue, hsync, vsync and blank SHALL all be registered from that same counter state. Total latency from coordinate to DAC outputs is exactly 1 cycle.
REQ-019 Sync outputs, registered from the counter state:
  - hsync SHALL be 0 exactly when h_cnt is in 656..751.
  - vsync SHALL be 0 exactly when v_cnt is in 490..491.
REQ-020 blank SHALL be 1 only when h_cnt<640 and v_cnt<480; when blank is 0, red/green/blue SHALL be 0 regardless of color_in.
REQ-021 Colour expansion (R=color_in[7:5], G=[4:2], B=[1:0]):
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - Thus 3'b111 maps to 8'hFF and 0 maps to 8'h00.
REQ-022 frame_tick SHALL be 1 for exactly one cycle, registered, when h_cnt=0 and v_cnt=480 (start of vertical front porch); once per 420000 cycles.
REQ-023 color_in SHALL be ignored outside the active area; no handshake, the consumer must supply colour every cycle.

Reset
REQ-024 While reset is 1:
  - h_cnt=0, v_cnt=0, both FSMs in ACTIVE.
  - hsync=1, vsync=1, blank=0, red=green=blue=0, frame_tick=0.
  - next_x=0, next_y=0.
REQ-025 On the first rising edge after reset deasserts, h_cnt SHALL become 1; the output registers SHALL reflect the pixel at (0,0).
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse held.

Structure
REQ-027 Timing constants (active, porch, sync, total per axis) and the phase enum SHALL live in shared package vga_timing_pkg.
REQ-028 A sub-module vga_axis_counter (count, wrap, phase FSM, sync/active flags; parameterised by the package constants; advance-enable input) SHALL be instantiated once per axis.

Verification
REQ-029 Reset release, run 800 cycles:
  - hsync low for exactly 96 consecutive cycles, first low output on the edge after h_cnt=656.
  - next_x sequence 0..639 then 0.
REQ-030 Run 420000 cycles: vsync low for exactly 1600 cycles; frame_tick exactly one pulse, on the edge after v_cnt=480 and h_cnt=0.
REQ-031 color_in=8'hFF at (0,0) -> next cycle red=green=blue=8'hFF and blank=1; color_in=8'hE0 -> red=8'hFF, green=0, blue=0.
REQ-032 color_in=8'hFF held constant through blanking (h_cnt 640..799) -> red=green=blue=0 and blank=0 on every one of those output cycles.
REQ-033 Assert reset at h_cnt=700, v_cnt=300 -> hsync=1, vsync=1, blank=0 immediately with no clock edge needed; after release, the frame restarts from (0,0).
REQ-034 Wrap boundary: at h_cnt=799, v_cnt=524, the next edge gives h_cnt=0, v_cnt=0, next_x=0, next_y=0.
